// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared types and helpers for the sequential AES key schedule
package aes_key_pkg;

    typedef enum logic [1:0] {
        KEY_128  = 2'b00,
        KEY_192  = 2'b01,
        KEY_256  = 2'b10,
        KEY_RSVD = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_DRAIN = 2'd2
    } exp_state_e;

    localparam logic [3:0] NK_256 = 4'd8;

    function automatic logic [3:0] nk_of(input key_len_e len);
        case (len)
            KEY_128: return 4'd4;
            KEY_192: return 4'd6;
            KEY_256: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e len);
        return nk_of(len) + 4'd6;
    endfunction

    // Rcon[j+1] = xtime(Rcon[j]) in GF(2^8)
    function automatic logic [7:0] rcon_next(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_word_step.sv
// rtl/aes_key_word_step.sv - one expanded word w[i] from w[i-1], w[i-Nk] and the Rcon in effect
module aes_key_word_step
    import aes_key_pkg::*;
(
    input  logic [31:0] w_prev,
    input  logic [31:0] w_nk,
    input  logic [2:0]  mod,
    input  logic [3:0]  nk,
    input  logic [7:0]  rcon,
    output logic [31:0] w_out
);

    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] t;

    assign sub_in = (mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        rev_aes_sbox u_sbox (
            .a (sub_in[8*g +: 8]),
            .y (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        t = w_prev;
        if (mod == 3'd0)
            t = sub_out ^ {rcon, 24'h000000};
        else if (nk == NK_256 && mod == 3'd4)
            t = sub_out;
        w_out = w_nk ^ t;
    end

endmodule

// File: rtl/rev_aes_sbox.sv
// rtl/rev_aes_sbox.sv - AES forward S-box: GF(2^8) inverse followed by the affine map
module rev_aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = x;
        bb = z;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] b;
        r = 8'h01;
        b = x;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) r = gf_mul(r, b);
            b = gf_mul(b, b);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        y   = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - sequential AES-128/192/256 key expansion streaming round keys
// Optional round-key store enabled by defining AES_KEY_EXP_STORE_EN.
module aes_key_expand_seq
    import aes_key_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256,
    parameter int RK_IDX_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [1:0]              key_len,
    input  logic [MAX_KEY_BITS-1:0] key_in,
    output logic                    busy,
    output logic                    err,
    output logic                    rk_valid,
    input  logic                    rk_ready,
    output logic [RK_IDX_W-1:0]     rk_idx,
    output logic [127:0]            rk_data,
    output logic                    done,
    input  logic [RK_IDX_W-1:0]     rd_idx,
    output logic [127:0]            rd_key
);

    localparam int WIN    = MAX_KEY_BITS / 32;
    localparam int NR_MAX = WIN + 6;

    exp_state_e state_q, state_d;

    logic                    accept, err_set, done_set;
    logic                    gen_fire, move, hs, slot_free, asm_full;
    logic                    key_phase, last_word, abort_run, len_ok;
    logic [3:0]              nk_q;
    logic [RK_IDX_W-1:0]     nr_q, asm_round;
    logic [5:0]              last_q, gen_idx;
    logic [2:0]              mod_q, asm_cnt;
    logic [7:0]              rcon_q;
    logic [MAX_KEY_BITS-1:0] key_sh;
    logic [31:0]             win [0:WIN-1];
    logic [127:0]            asm_buf;
    logic [31:0]             w_nk, w_step, w_new;
    key_len_e                len_e;

    assign len_e     = key_len_e'(key_len);
    assign len_ok    = (len_e != KEY_RSVD) && (32 * int'(nk_of(len_e)) <= MAX_KEY_BITS);
    assign slot_free = !rk_valid || rk_ready;
    assign asm_full  = (asm_cnt == 3'd4);
    assign hs        = rk_valid && rk_ready;
    assign move      = (state_q != ST_IDLE) && asm_full && slot_free;
    assign gen_fire  = (state_q == ST_GEN) && (!asm_full || slot_free);
    assign key_phase = gen_idx < {2'b00, nk_q};
    assign last_word = (gen_idx == last_q);
    assign abort_run = abort && (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign w_new     = key_phase ? key_sh[MAX_KEY_BITS-1 -: 32] : w_step;

    // w[i-Nk] sits at depth Nk-1 of the window, w[i-1] at depth 0
    always_comb begin
        w_nk = '0;
        for (int k = 0; k < WIN; k++) begin
            if (nk_q == 4'(k + 1)) w_nk = win[k];
        end
    end

    aes_key_word_step u_step (
        .w_prev (win[0]),
        .w_nk   (w_nk),
        .mod    (mod_q),
        .nk     (nk_q),
        .rcon   (rcon_q),
        .w_out  (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        err_set  = 1'b0;
        done_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (len_ok) begin
                        accept  = 1'b1;
                        state_d = ST_GEN;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_GEN: begin
                if (abort)                      state_d = ST_IDLE;
                else if (gen_fire && last_word) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hs && rk_idx == nr_q) begin
                    state_d  = ST_IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            done      <= 1'b0;
            nk_q      <= '0;
            nr_q      <= '0;
            last_q    <= '0;
            key_sh    <= '0;
            gen_idx   <= '0;
            mod_q     <= '0;
            rcon_q    <= '0;
            asm_buf   <= '0;
            asm_cnt   <= '0;
            asm_round <= '0;
            rk_valid  <= 1'b0;
            rk_data   <= '0;
            rk_idx    <= '0;
            for (int k = 0; k < WIN; k++) win[k] <= '0;
        end else begin
            err  <= err_set;
            done <= done_set;
            if (accept) begin
                nk_q      <= nk_of(len_e);
                nr_q      <= RK_IDX_W'(nr_of(len_e));
                last_q    <= {nr_of(len_e), 2'b11};
                key_sh    <= key_in;
                gen_idx   <= '0;
                mod_q     <= '0;
                rcon_q    <= 8'h01;
                asm_cnt   <= '0;
                asm_round <= '0;
                rk_valid  <= 1'b0;
                for (int k = 0; k < WIN; k++) win[k] <= '0;
            end else if (abort_run) begin
                rk_valid <= 1'b0;
                asm_cnt  <= '0;
            end else begin
                if (gen_fire) begin
                    win[0] <= w_new;
                    for (int k = 1; k < WIN; k++) win[k] <= win[k-1];
                    key_sh  <= key_sh << 32;
                    gen_idx <= gen_idx + 6'd1;
                    mod_q   <= ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
                    if (!key_phase && mod_q == 3'd0) rcon_q <= rcon_next(rcon_q);
                    asm_buf <= {asm_buf[95:0], w_new};
                end
                // a draining buffer and a freshly generated word can share one edge
                if (move && gen_fire) asm_cnt <= 3'd1;
                else if (move)        asm_cnt <= 3'd0;
                else if (gen_fire)    asm_cnt <= asm_cnt + 3'd1;
                if (move) begin
                    rk_valid  <= 1'b1;
                    rk_data   <= asm_buf;
                    rk_idx    <= asm_round;
                    asm_round <= asm_round + 1'b1;
                end else if (hs) begin
                    rk_valid <= 1'b0;
                end
            end
        end
    end

`ifdef AES_KEY_EXP_STORE_EN
    logic [127:0]        store_q [0:NR_MAX];
    logic [RK_IDX_W-1:0] last_st_q;
    logic                have_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NR_MAX; k++) store_q[k] <= '0;
            last_st_q <= '0;
            have_q    <= 1'b0;
            rd_key    <= '0;
        end else begin
            if (hs) begin
                store_q[rk_idx] <= rk_data;
                last_st_q       <= rk_idx;
                have_q          <= 1'b1;
            end
            rd_key <= (have_q && rd_idx <= last_st_q) ? store_q[rd_idx] : '0;
        end
    end
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - directed-vector bench for aes_key_expand_seq
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key_in = '0;
    logic         busy, err, rk_valid, done;
    logic         rk_ready = 1'b0;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data, rd_key;
    logic [3:0]   rd_idx = 4'd0;

    always #5 clk = ~clk;

    aes_key_expand_seq #(.MAX_KEY_BITS(256), .RK_IDX_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .err      (err),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_idx   (rk_idx),
        .rk_data  (rk_data),
        .done     (done),
        .rd_idx   (rd_idx),
        .rd_key   (rd_key)
    );

    localparam logic [127:0] EXP128 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] EXP256 [0:3] = '{
        128'h603deb1015ca71be2b73aef0857d7781,
        128'h1f352c073b6108d72d9810a30914dff4,
        128'h9ba354118e6925afa51a8b5f2067fcde,
        128'ha8b09c1a93d194cdbe49846eb75d5b9a
    };
    localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] RK192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int           total = 0;
    int           bad = 0;
    logic [127:0] got [0:14];
    int           vcyc [0:14];
    int           done_early;
    int           err_seen;
    logic [127:0] expv;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Starts an expansion from a negedge and collects round keys until Nr+1 or abort_after handshakes.
    task automatic run_exp(input logic [1:0] len, input logic [255:0] key, input int nr,
                           input int pct, input int abort_after, input bit poke_start);
        int           n = 0;
        int           cyc = -1;
        bit           held = 1'b0;
        bit           rdy;
        logic [127:0] hd = '0;
        logic [3:0]   hi = '0;
        done_early = 0;
        err_seen   = 0;
        for (int i = 0; i < 15; i++) begin
            got[i]  = '0;
            vcyc[i] = -1;
        end
        key_len = len;
        key_in  = key;
        start   = 1'b1;
        while (n <= nr && cyc < 3000 && n != abort_after) begin
            @(negedge clk);
            cyc++;
            start = poke_start && (cyc == 20);
            if (done) done_early++;
            if (err) err_seen++;
            if (held) begin
                check_eq("stable_data", rk_data, hd);
                check_eq("stable_idx", 128'(rk_idx), 128'(hi));
            end
            held     = 1'b0;
            rdy      = ($urandom_range(0, 99) < pct);
            rk_ready = rdy;
            if (rk_valid) begin
                if (rk_idx <= 4'd14 && vcyc[rk_idx] < 0) vcyc[rk_idx] = cyc;
                if (rdy) begin
                    check_eq($sformatf("order%0d", n), 128'(rk_idx), 128'(n));
                    if (n < 15) got[n] = rk_data;
                    n++;
                end else begin
                    held = 1'b1;
                    hd   = rk_data;
                    hi   = rk_idx;
                end
            end
        end
        start = 1'b0;
        if (abort_after < 0) begin
            check_eq("keys_seen", 128'(n), 128'(nr + 1));
            @(negedge clk);
            rk_ready = 1'b0;
            check_eq("done_pulse", 128'(done), 128'(1));
            check_eq("busy_after_done", 128'(busy), 128'(0));
            check_eq("no_early_done", 128'(done_early), 128'(0));
            check_eq("no_err_in_run", 128'(err_seen), 128'(0));
            @(negedge clk);
            check_eq("done_one_cycle", 128'(done), 128'(0));
        end else begin
            check_eq("keys_before_abort", 128'(n), 128'(abort_after));
            @(negedge clk);
            rk_ready = 1'b0;
            abort    = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check_eq("abort_valid", 128'(rk_valid), 128'(0));
            check_eq("abort_busy", 128'(busy), 128'(0));
            repeat (10) begin
                @(negedge clk);
                if (done) done_early++;
            end
            check_eq("abort_no_done", 128'(done_early), 128'(0));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("reset_outs", {122'(0), busy, err, rk_valid, done, rk_idx != 4'd0, rk_data != 128'd0},
                 128'd0);
        check_eq("reset_rd_key", rd_key, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // AES-128, always ready, with a stray start mid-run
        run_exp(2'b00, KEY128, 10, 100, -1, 1'b1);
        check_eq("a128_rk0", got[0], EXP128[0]);
        check_eq("a128_rk1", got[1], EXP128[1]);
        check_eq("a128_rk10", got[10], EXP128[10]);
        check_eq("lat_rk0", 128'(vcyc[0]), 128'(5));
        check_eq("period_rk1", 128'(vcyc[1] - vcyc[0]), 128'(4));
        check_eq("period_rk10", 128'(vcyc[10] - vcyc[9]), 128'(4));

        // AES-128 under random backpressure
        run_exp(2'b00, KEY128, 10, 30, -1, 1'b0);
        for (int r = 0; r <= 10; r++) check_eq($sformatf("bp_rk%0d", r), got[r], EXP128[r]);

        // reserved key length
        key_len = 2'b11;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("err_pulse", 128'(err), 128'(1));
        check_eq("err_busy", 128'(busy), 128'(0));
        @(negedge clk);
        check_eq("err_one_cycle", 128'(err), 128'(0));

        // abort together with start in IDLE
        key_len = 2'b00;
        start   = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_eq("abort_start_busy", 128'(busy), 128'(0));
        check_eq("abort_start_err", 128'(err), 128'(0));

        // abort after round 3, then a fresh run
        run_exp(2'b00, KEY128, 10, 100, 4, 1'b0);
        for (int r = 0; r < 4; r++) check_eq($sformatf("pre_abort_rk%0d", r), got[r], EXP128[r]);
        run_exp(2'b00, KEY128, 10, 100, -1, 1'b0);
        check_eq("fresh_rk0", got[0], EXP128[0]);
        check_eq("fresh_rk10", got[10], EXP128[10]);

        run_exp(2'b01, KEY192, 12, 100, -1, 1'b0);
        check_eq("a192_rk0", got[0], RK192_0);
        check_eq("a192_rk12", got[12], RK192_12);

        run_exp(2'b10, KEY256, 14, 60, -1, 1'b0);
        for (int r = 0; r < 4; r++) check_eq($sformatf("a256_rk%0d", r), got[r], EXP256[r]);
        check_eq("a256_rk14", got[14], RK256_14);

`ifdef AES_KEY_EXP_STORE_EN
        for (int r = 0; r < 16; r++) begin
            rd_idx = 4'(r);
            @(negedge clk);
            if (r == 15)     expv = '0;
            else if (r < 4)  expv = EXP256[r];
            else if (r == 14) expv = RK256_14;
            else             expv = got[r];
            check_eq($sformatf("store%0d", r), rd_key, expv);
        end
`else
        rd_idx = 4'd5;
        @(negedge clk);
        expv = '0;
        check_eq("no_store", rd_key, expv);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
